// File: rtl/peripheral_mpram_bridge_tl.sv
// TileLink-UL to single-port memory bridge.
// Accepts one A-channel request at a time and turns it into a single memory
// strobe. A Put finishes with an AccessAck. A Get waits one cycle for the
// registered memory read data and then returns an AccessAckData. Unsupported
// or oversized requests get an immediate error response and never touch the
// memory.
module peripheral_mpram_bridge_tl #(
  parameter int PLEN        = 64,
  parameter int XLEN        = 64,
  parameter int SOURCE_BITS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  // A channel
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [2:0]             a_opcode,
  input  logic [2:0]             a_size,
  input  logic [SOURCE_BITS-1:0] a_source,
  input  logic [PLEN-1:0]        a_address,
  input  logic [XLEN/8-1:0]      a_mask,
  input  logic [XLEN-1:0]        a_data,
  // D channel
  output logic                   d_valid,
  input  logic                   d_ready,
  output logic [2:0]             d_opcode,
  output logic [2:0]             d_size,
  output logic [SOURCE_BITS-1:0] d_source,
  output logic [XLEN-1:0]        d_data,
  output logic                   d_error,
  // Memory port
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  output logic [XLEN/16-1:0]     mem_be_o,
  output logic [PLEN-1:0]        mem_addr_o,
  output logic [XLEN-1:0]        mem_data_o,
  input  logic [XLEN-1:0]        mem_data_i
);

  localparam int         BYTES    = XLEN / 8;
  localparam int         LANES    = XLEN / 16;
  // Largest legal a_size: one full data beat.
  localparam logic [2:0] MAX_SIZE = 3'($clog2(BYTES));

  typedef enum logic [2:0] {
    PUT_FULL    = 3'd0,
    PUT_PARTIAL = 3'd1,
    GET         = 3'd4
  } a_op_e;

  localparam logic [2:0] ACCESS_ACK      = 3'd0;
  localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e state_q, state_d;

  // Latched request and response registers.
  logic [2:0]             op_q;
  logic [2:0]             size_q;
  logic [SOURCE_BITS-1:0] source_q;
  logic [PLEN-1:0]        addr_q;
  logic [XLEN-1:0]        data_q;
  logic [LANES-1:0]       be_q;
  logic                   err_q;
  logic [2:0]             d_opcode_q;
  logic [XLEN-1:0]        d_data_q;

  // Decoded incoming request.
  logic             a_fire;
  logic             op_ok;
  logic             req_err;
  logic [LANES-1:0] be_d;

  // Decode the A-channel request: legality check and 16-bit lane enables.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    a_ready = (state_q == IDLE) && !rst;
    a_fire  = a_valid && a_ready;
    op_ok   = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL) || (a_opcode == GET);
    req_err = !op_ok || (a_size > MAX_SIZE);
    be_d    = '1;
    if (a_opcode == PUT_PARTIAL) begin
      for (int i = 0; i < LANES; i++) begin
        be_d[i] = a_mask[2*i] | a_mask[2*i+1];
      end
    end
  end

  // Next-state logic of the transaction FSM.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (a_fire) state_d = req_err ? RESP : ISSUE;
      ISSUE:   state_d = (op_q == GET) ? READ : RESP;
      READ:    state_d = RESP;
      RESP:    if (d_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Request latch on A handshake and read-data capture in READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= '0;
      size_q     <= '0;
      source_q   <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      be_q       <= '0;
      err_q      <= 1'b0;
      d_opcode_q <= ACCESS_ACK;
      d_data_q   <= '0;
    end else begin
      if (a_fire) begin
        op_q       <= a_opcode;
        size_q     <= a_size;
        source_q   <= a_source;
        addr_q     <= a_address;
        data_q     <= a_data;
        be_q       <= be_d;
        err_q      <= req_err;
        d_opcode_q <= ACCESS_ACK;
        d_data_q   <= '0;
      end
      if (state_q == READ) begin
        d_data_q   <= mem_data_i;
        d_opcode_q <= ACCESS_ACK_DATA;
      end
    end
  end

  // Memory strobes exist only in ISSUE and are killed immediately by reset,
  // so a reset landing on ISSUE cannot complete a write.
  assign mem_req_o  = (state_q == ISSUE) && !rst;
  assign mem_we_o   = (state_q == ISSUE) && (op_q != GET) && !rst;
  assign mem_be_o   = be_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = data_q;

  // Response fields come straight from registers and hold while RESP stalls.
  assign d_valid  = (state_q == RESP);
  assign d_opcode = d_opcode_q;
  assign d_size   = size_q;
  assign d_source = source_q;
  assign d_data   = d_data_q;
  assign d_error  = err_q;

endmodule
